fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of write requesters sharing one FIFO write port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of each data word.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum number of words accepted per grant (>=1).
REQ-004 i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_Rst  input  1  reset, synchronous, active-high.
REQ-006 i_Req_valid  input  NUM_REQ  bit k high = requester k presents a word.
REQ-007 i_Req_data  input  NUM_REQ*DATA_WIDTH  requester k word on bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 o_Req_ready  output  NUM_REQ  bit k high = requester k word accepted this cycle if valid.
REQ-009 i_Full  input  1  FIFO write-side full flag, registered, in the i_Clk domain.
REQ-010 o_W_en  output  1  FIFO write enable.
REQ-011 o_W_data  output  DATA_WIDTH  FIFO write data.
REQ-012 o_Gnt  output  NUM_REQ  registered one-hot grant vector; all-zero when idle.
REQ-013 o_Busy  output  1  high while in state GRANT.
REQ-014 o_Stall_cnt  output  16  saturating count of cycles a granted, valid requester was blocked by i_Full.

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 In IDLE with any i_Req_valid bit set, the block SHALL select the first set bit searching upward (modulo NUM_REQ) from the priority pointer, load o_Gnt with it, clear the burst counter, and enter GRANT next cycle.
REQ-017 In IDLE with no request, the block SHALL remain in IDLE with o_Gnt = 0.
REQ-018 In GRANT, o_Req_ready[g] SHALL equal !i_Full for the granted index g; all other ready bits SHALL be 0; in IDLE all ready bits SHALL be 0.
REQ-019 A transfer SHALL occur when i_Req_valid[g] and o_Req_ready[g] are both high; o_W_en SHALL be high and o_W_data SHALL equal requester g word in that same cycle (combinational, zero latency).
REQ-020 o_W_en SHALL never be high while i_Full is high; o_W_data SHALL be 0 when o_W_en is low.
REQ-021 Each transfer SHALL increment the burst counter (width clog2(MAX_BURST)+1).
REQ-022 GRANT SHALL be released (next state IDLE, o_Gnt cleared) when a transfer occurs with burst count equal to MAX_BURST-1, or when i_Req_valid[g] is low.
REQ-023 On release, the priority pointer SHALL be set to (g+1) mod NUM_REQ.
REQ-024 In GRANT with i_Req_valid[g] high and i_Full high, the block SHALL hold the grant, not count a transfer, and increment o_Stall_cnt unless at 16'hFFFF.
REQ-025 Every burst SHALL be followed by at least one IDLE cycle (one-cycle arbitration bubble).
REQ-026 Requests from non-granted requesters SHALL have no effect until the next IDLE arbitration.
REQ-027 The block SHALL not drop or duplicate words: each word with valid&ready high is written exactly once.

Reset
REQ-028 While i_Rst is high at a rising edge, the block SHALL enter IDLE, clear o_Gnt, priority pointer, burst counter and o_Stall_cnt to 0; o_W_en, o_Req_ready and o_Busy SHALL be 0 the following cycle.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no further write; words already written stay written.

Verification
REQ-030 Reset then requester 2 valid for 6 cycles, i_Full=0, MAX_BURST=4 -> grant to 2 after 1 IDLE cycle, 4 writes, IDLE, regrant to 2, 2 writes.
REQ-031 All 4 requesters continuously valid -> grants in order 0,1,2,3,0, each burst 4 writes separated by 1 idle cycle.
REQ-032 Requester 1 granted, i_Full high 3 cycles mid-burst -> o_W_en low those 3 cycles, grant held, o_Stall_cnt = 3, burst completes with 4 total writes.
REQ-033 Requester 3 granted, drops valid after 2 writes -> release to IDLE, pointer = 0, exactly 2 writes.
REQ-034 i_Rst pulsed during second write of a burst -> next cycle IDLE, o_Gnt = 0, o_Stall_cnt = 0, no further o_W_en until a new grant.
REQ-035 i_Full held high 70000 cycles with granted valid requester -> o_Stall_cnt saturates at 16'hFFFF, zero writes.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ producers share one
// FIFO write port. A grant lasts up to MAX_BURST words and is followed by one
// idle arbitration cycle. The data path is combinational, so a word is written
// in the same cycle it is accepted.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          i_Clk,
   input  logic                          i_Rst,
   input  logic [NUM_REQ-1:0]            i_Req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_data,
   output logic [NUM_REQ-1:0]            o_Req_ready,
   input  logic                          i_Full,
   output logic                          o_W_en,
   output logic [DATA_WIDTH-1:0]         o_W_data,
   output logic [NUM_REQ-1:0]            o_Gnt,
   output logic                          o_Busy,
   output logic [15:0]                   o_Stall_cnt
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state;
   logic [GW-1:0]   gnt_idx;
   logic [GW-1:0]   ptr;
   logic [GW-1:0]   arb_idx;
   logic            arb_found;
   logic [BW-1:0]   burst_cnt;
   logic            busy;
   logic            g_valid;
   logic            xfer;
   logic            last_word;
   logic [GW-1:0]   ptr_next;

   assign busy      = (state == GRANT);
   assign g_valid   = i_Req_valid[gnt_idx];
   // A word moves only while granted, the owner is valid and the FIFO has room.
   assign xfer      = busy && g_valid && !i_Full;
   assign last_word = (burst_cnt == BW'(MAX_BURST - 1));
   // Next search starts just past the requester that owned the last grant.
   assign ptr_next  = (gnt_idx == GW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   assign o_Busy      = busy;
   assign o_Req_ready = (busy && !i_Full) ? o_Gnt : '0;
   assign o_W_en      = xfer;
   assign o_W_data    = xfer ? i_Req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

   // Round-robin pick: first valid requester at or above the priority pointer, wrapping.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!arb_found && i_Req_valid[(int'(ptr) + i) % NUM_REQ]) begin
            arb_found = 1'b1;
            arb_idx   = GW'((int'(ptr) + i) % NUM_REQ);
         end
      end
   end

   // Grant FSM: arbitrate in IDLE, stream a burst in GRANT, release on burst end or valid drop.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= IDLE;
         o_Gnt       <= '0;
         gnt_idx     <= '0;
         ptr         <= '0;
         burst_cnt   <= '0;
         o_Stall_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_found) begin
                  o_Gnt     <= NUM_REQ'(1) << arb_idx;
                  gnt_idx   <= arb_idx;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end else begin
                  o_Gnt <= '0;
               end
            end
            GRANT: begin
               if (!g_valid) begin
                  // Owner went away: give the port back without counting anything.
                  state <= IDLE;
                  o_Gnt <= '0;
                  ptr   <= ptr_next;
               end else if (i_Full) begin
                  // Owner blocked by a full FIFO: hold the grant and record the stall.
                  if (o_Stall_cnt != 16'hFFFF)
                     o_Stall_cnt <= o_Stall_cnt + 16'd1;
               end else begin
                  burst_cnt <= burst_cnt + 1'b1;
                  if (last_word) begin
                     state <= IDLE;
                     o_Gnt <= '0;
                     ptr   <= ptr_next;
                  end
               end
            end
            default: begin
               state <= IDLE;
               o_Gnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Inputs change 1ns after a rising edge; outputs are checked 2ns after that,
// well away from the next edge.
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        full;
   logic        w_en;
   logic [7:0]  w_data;
   logic [3:0]  gnt;
   logic        busy;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .i_Clk       (clk),
      .i_Rst       (rst),
      .i_Req_valid (req_valid),
      .i_Req_data  (req_data),
      .o_Req_ready (req_ready),
      .i_Full      (full),
      .o_W_en      (w_en),
      .o_W_data    (w_data),
      .o_Gnt       (gnt),
      .o_Busy      (busy),
      .o_Stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then settle 1ns past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic chk_write(input string tag, input logic [3:0] g, input logic [7:0] d);
      chk({tag, "_gnt"},   gnt,   g);
      chk({tag, "_ready"}, req_ready, g);
      chk({tag, "_wen"},   w_en,  1'b1);
      chk({tag, "_wdata"}, w_data, d);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"},  gnt,  4'b0000);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_wen"},  w_en, 1'b0);
      chk({tag, "_wdata"}, w_data, 8'h00);
   endtask

   initial begin
      int exp_order [5];
      int nwr;
      rst       = 1'b0;
      req_valid = 4'b0000;
      req_data  = 32'h44332211;
      full      = 1'b0;
      exp_order = '{0, 1, 2, 3, 0};
      #1;

      // ---- reset state ----
      do_reset();
      settle();
      chk_idle("rst");
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_stall", stall_cnt, 16'h0000);

      // ---- requester 2 alone: burst of 4, bubble, regrant for 2 more ----
      req_valid = 4'b0100;
      settle();
      chk_idle("a_arb0");
      step();
      for (int n = 0; n < 4; n++) begin
         req_data[23:16] = 8'hA0 + 8'(n);
         settle();
         chk_write($sformatf("a_w%0d", n), 4'b0100, 8'hA0 + 8'(n));
         chk($sformatf("a_w%0d_busy", n), busy, 1'b1);
         step();
      end
      settle();
      chk_idle("a_bubble");
      chk("a_bubble_ready", req_ready, 4'b0000);
      step();
      for (int n = 4; n < 6; n++) begin
         req_data[23:16] = 8'hA0 + 8'(n);
         settle();
         chk_write($sformatf("a_w%0d", n), 4'b0100, 8'hA0 + 8'(n));
         step();
      end
      req_valid = 4'b0000;
      settle();
      chk("a_drop_wen", w_en, 1'b0);
      chk("a_drop_gnt", gnt, 4'b0100);
      step();
      settle();
      chk_idle("a_end");

      // ---- all four valid: round robin 0,1,2,3,0 ----
      do_reset();
      req_data  = 32'h44332211;
      req_valid = 4'b1111;
      for (int b = 0; b < 5; b++) begin
         settle();
         chk_idle($sformatf("b_idle%0d", b));
         step();
         for (int n = 0; n < 4; n++) begin
            settle();
            chk_write($sformatf("b_g%0d_w%0d", b, n), 4'(1 << exp_order[b]),
                      8'(8'h11 * (exp_order[b] + 1)));
            step();
         end
      end
      req_valid = 4'b0000;

      // ---- requester 1 stalled 3 cycles by full mid-burst ----
      do_reset();
      req_valid = 4'b0010;
      nwr = 0;
      step();
      for (int n = 0; n < 2; n++) begin
         settle();
         chk_write($sformatf("c_w%0d", n), 4'b0010, 8'h22);
         nwr += int'(w_en);
         step();
      end
      full = 1'b1;
      for (int n = 0; n < 3; n++) begin
         settle();
         chk($sformatf("c_st%0d_wen", n), w_en, 1'b0);
         chk($sformatf("c_st%0d_ready", n), req_ready, 4'b0000);
         chk($sformatf("c_st%0d_gnt", n), gnt, 4'b0010);
         nwr += int'(w_en);
         step();
      end
      full = 1'b0;
      settle();
      chk("c_stall_cnt", stall_cnt, 16'd3);
      for (int n = 2; n < 4; n++) begin
         settle();
         chk_write($sformatf("c_w%0d", n), 4'b0010, 8'h22);
         nwr += int'(w_en);
         step();
      end
      settle();
      chk_idle("c_end");
      chk("c_writes", nwr, 4);
      req_valid = 4'b0000;

      // ---- requester 3 drops valid after 2 writes; pointer wraps to 0 ----
      do_reset();
      req_valid = 4'b1000;
      step();
      for (int n = 0; n < 2; n++) begin
         settle();
         chk_write($sformatf("d_w%0d", n), 4'b1000, 8'h44);
         step();
      end
      req_valid = 4'b0000;
      settle();
      chk("d_drop_wen", w_en, 1'b0);
      step();
      settle();
      chk_idle("d_rel");
      req_valid = 4'b1111;
      step();
      settle();
      chk("d_next_gnt", gnt, 4'b0001);
      req_valid = 4'b0000;

      // ---- reset during second write aborts burst and clears stall count ----
      do_reset();
      req_valid = 4'b0001;
      step();
      full = 1'b1;
      step();
      full = 1'b0;
      settle();
      chk("e_pre_stall", stall_cnt, 16'd1);
      chk_write("e_w0", 4'b0001, 8'h11);
      step();
      rst = 1'b1;
      settle();
      chk_write("e_w1", 4'b0001, 8'h11);
      step();
      rst = 1'b0;
      settle();
      chk_idle("e_post");
      chk("e_post_stall", stall_cnt, 16'h0000);
      chk("e_post_ready", req_ready, 4'b0000);
      step();
      settle();
      chk_write("e_regrant", 4'b0001, 8'h11);
      req_valid = 4'b0000;

      // ---- long full: stall counter saturates, nothing written ----
      do_reset();
      req_valid = 4'b0001;
      step();
      full = 1'b1;
      nwr = 0;
      for (int n = 0; n < 70000; n++) begin
         settle();
         nwr += int'(w_en);
         step();
      end
      settle();
      chk("f_stall_sat", stall_cnt, 16'hFFFF);
      chk("f_writes", nwr, 0);
      chk("f_gnt_held", gnt, 4'b0001);
      full = 1'b0;
      req_valid = 4'b0000;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
